// File: rtl/mult_arb_pkg.sv
// Shared constants, pipeline stage records and adder-cell helpers for the
// arbitrated 4x4 multiplier.
package mult_arb_pkg;

  localparam int OPW    = 4;
  localparam int PRODW  = 8;
  localparam int IDMAXW = 3;

  typedef struct packed {
    logic              valid;
    logic [IDMAXW-1:0] id;
    logic [OPW-1:0]    a;
    logic [OPW-1:0]    b;
  } s1_t;

  typedef struct packed {
    logic              valid;
    logic [IDMAXW-1:0] id;
    logic [PRODW-1:0]  prod;
  } s2_t;

  // Returns {carry, sum}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from ptr with wrap-around
// and grants the first active request (one-hot).
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt
);

  logic [IDW:0] idx_s;
  logic [IDW:0] sum_s;
  logic         found_s;
  logic         hit_s;

  // Priority scan starting at the pointer position.
  always_comb begin
    gnt     = {NREQ{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    sum_s   = {(IDW+1){1'b0}};
    idx_s   = {(IDW+1){1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      sum_s   = {1'b0, ptr} + (IDW+1)'(k);
      idx_s   = (sum_s >= (IDW+1)'(NREQ)) ? (sum_s - (IDW+1)'(NREQ)) : sum_s;
      hit_s   = ~found_s & req[idx_s[IDW-1:0]];
      gnt[idx_s[IDW-1:0]] = gnt[idx_s[IDW-1:0]] | hit_s;
      found_s = found_s | hit_s;
    end
  end

endmodule

// File: rtl/wallace.sv
// 4x4 unsigned Wallace-tree multiplier: partial products are reduced with
// full/half adders down to three sparse rows, then summed.
module wallace
  import mult_arb_pkg::*;
(
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [PRODW-1:0] prod
);

  logic [OPW-1:0]   pp_s [OPW];
  logic [1:0]       h1_s, f2_s, f3_s, f4_s, h5_s, f3b_s;
  logic [PRODW-1:0] row_x_s, row_y_s, row_z_s;

  for (genvar i = 0; i < OPW; i++) begin : g_pp
    assign pp_s[i] = a & {OPW{b[i]}};
  end

  // pp_s[i][j] carries weight i+j; first layer compresses each column.
  assign h1_s  = ha(pp_s[0][1], pp_s[1][0]);
  assign f2_s  = fa(pp_s[0][2], pp_s[1][1], pp_s[2][0]);
  assign f3_s  = fa(pp_s[0][3], pp_s[1][2], pp_s[2][1]);
  assign f4_s  = fa(pp_s[1][3], pp_s[2][2], pp_s[3][1]);
  assign h5_s  = ha(pp_s[2][3], pp_s[3][2]);
  assign f3b_s = fa(f3_s[0], pp_s[3][0], f2_s[1]);

  assign row_x_s = {1'b0, pp_s[3][3], h5_s[0], f4_s[0], f3b_s[0], f2_s[0], h1_s[0], pp_s[0][0]};
  assign row_y_s = {1'b0, h5_s[1], f4_s[1], f3_s[1], 1'b0, h1_s[1], 1'b0, 1'b0};
  assign row_z_s = {3'b000, f3b_s[1], 4'b0000};

  assign prod = row_x_s + row_y_s + row_z_s;

endmodule

// File: rtl/mult_arbiter.sv
// NREQ requesters share one 4x4 multiplier through a round-robin grant and a
// two-stage valid/ready pipeline (S1 operands, S2 product).
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [PRODW-1:0]  rsp_prod,
  output logic              busy
);

  s1_t              s1_r, s1_nxt_s;
  s2_t              s2_r, s2_nxt_s;
  logic [IDW-1:0]   ptr_r, ptr_nxt_s;
  logic             busy_r;

  logic             s2_drain_s;
  logic             s1_adv_s;
  logic             grant_ok_s;
  logic [NREQ-1:0]  arb_req_s;
  logic [NREQ-1:0]  gnt_s;
  logic [IDW-1:0]   gnt_id_s;
  logic [OPW-1:0]   gnt_a_s;
  logic [OPW-1:0]   gnt_b_s;
  logic [PRODW-1:0] prod_s;
  logic             unused_id_s;

  // A new grant is only offered when S1 has room this cycle; never during reset.
  always_comb begin
    s2_drain_s = s2_r.valid & rsp_ready;
    s1_adv_s   = s1_r.valid & (~s2_r.valid | s2_drain_s);
    grant_ok_s = ~s1_r.valid | s1_adv_s;
    arb_req_s  = (grant_ok_s & ~rst) ? req_valid : {NREQ{1'b0}};
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req (arb_req_s),
    .ptr (ptr_r),
    .gnt (gnt_s)
  );

  assign req_ready = gnt_s;

  // One-hot operand and ID select for the granted requester.
  always_comb begin
    gnt_id_s = {IDW{1'b0}};
    gnt_a_s  = {OPW{1'b0}};
    gnt_b_s  = {OPW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      gnt_id_s = gnt_id_s | (IDW'(i) & {IDW{gnt_s[i]}});
      gnt_a_s  = gnt_a_s  | (req_a[OPW*i +: OPW] & {OPW{gnt_s[i]}});
      gnt_b_s  = gnt_b_s  | (req_b[OPW*i +: OPW] & {OPW{gnt_s[i]}});
    end
  end

  wallace u_mult (
    .a    (s1_r.a),
    .b    (s1_r.b),
    .prod (prod_s)
  );

  // Stage, pointer and busy next-state.
  always_comb begin
    s1_nxt_s  = s1_r;
    s2_nxt_s  = s2_r;
    ptr_nxt_s = ptr_r;

    if (|gnt_s) begin
      s1_nxt_s.valid = 1'b1;
      s1_nxt_s.id    = IDMAXW'(gnt_id_s);
      s1_nxt_s.a     = gnt_a_s;
      s1_nxt_s.b     = gnt_b_s;
    end else if (s1_adv_s) begin
      s1_nxt_s.valid = 1'b0;
    end else begin
      s1_nxt_s.valid = s1_r.valid;
    end

    if (s1_adv_s) begin
      s2_nxt_s.valid = 1'b1;
      s2_nxt_s.id    = s1_r.id;
      s2_nxt_s.prod  = prod_s;
    end else if (s2_drain_s) begin
      s2_nxt_s.valid = 1'b0;
    end else begin
      s2_nxt_s.valid = s2_r.valid;
    end

    if (|gnt_s) begin
      ptr_nxt_s = (gnt_id_s == IDW'(NREQ-1)) ? {IDW{1'b0}} : (gnt_id_s + IDW'(1));
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r   <= '0;
      s2_r   <= '0;
      ptr_r  <= {IDW{1'b0}};
      busy_r <= 1'b0;
    end else begin
      s1_r   <= s1_nxt_s;
      s2_r   <= s2_nxt_s;
      ptr_r  <= ptr_nxt_s;
      busy_r <= s1_nxt_s.valid | s2_nxt_s.valid;
    end
  end

  assign rsp_valid   = s2_r.valid;
  assign rsp_id      = s2_r.id[IDW-1:0];
  assign rsp_prod    = s2_r.prod;
  assign busy        = busy_r;
  assign unused_id_s = ^s2_r.id;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: queue-based reference model checked
// every cycle, plus directed latency, ordering, backpressure, reset and fairness.
module tb_mult_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = 4'b0000;
  logic [15:0] req_a = 16'h0000;
  logic [15:0] req_b = 16'h0000;
  logic        rsp_ready = 1'b0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_prod;
  logic        busy;

  int total = 0;
  int bad = 0;
  int rsp_seen = 0;

  typedef struct {
    int id;
    int prod;
  } item_t;

  item_t front_q[$];
  item_t back_q[$];
  int    ptr_m = 0;

  mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rr_pick(input logic [3:0] v, input int p);
    logic [3:0] g;
    g = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (g == 4'b0000 && v[(p + k) % 4]) g[(p + k) % 4] = 1'b1;
    end
    return g;
  endfunction

  // Reference model: a result is visible once it sits in the output slot; the
  // entry slot accepts a new grant if it is empty or can move forward.
  always @(negedge clk) begin
    logic [3:0] eg;
    bit         space;
    item_t      it;
    if (rst) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_prod", rsp_prod, 0);
      chk("rst_rsp_id", rsp_id, 0);
      front_q.delete();
      back_q.delete();
      ptr_m = 0;
    end else begin
      chk("rsp_valid", rsp_valid, front_q.size() != 0);
      if (front_q.size() != 0) begin
        chk("rsp_id", rsp_id, front_q[0].id);
        chk("rsp_prod", rsp_prod, front_q[0].prod);
      end
      chk("busy", busy, (front_q.size() + back_q.size()) != 0);
      space = (back_q.size() == 0) || (front_q.size() == 0) || rsp_ready;
      eg = space ? rr_pick(req_valid, ptr_m) : 4'b0000;
      chk("req_ready", req_ready, eg);
      if (front_q.size() != 0 && rsp_ready) begin
        void'(front_q.pop_front());
        rsp_seen++;
      end
      if (back_q.size() != 0 && front_q.size() == 0) front_q.push_back(back_q.pop_front());
      for (int i = 0; i < 4; i++) begin
        if (eg[i]) begin
          it.id   = i;
          it.prod = int'(req_a[4*i +: 4]) * int'(req_b[4*i +: 4]);
          back_q.push_back(it);
          ptr_m = (i + 1) % 4;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq [5];
    logic [3:0] hs;
    int         nxt [4];
    int         cyc;
    int         base;
    int         wait3;
    bit         done;

    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;

    repeat (3) tick();
    rst = 1'b0;

    // Single request 15*15 from requester 0.
    req_valid = 4'b0001; req_a = 16'h000F; req_b = 16'h000F; rsp_ready = 1'b1;
    #3 chk("single_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    #3 chk("single_early", rsp_valid, 0);
    tick();
    #3;
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 0);
    chk("single_prod", rsp_prod, 225);
    tick();

    // Pointer back to 0, then all four held valid.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    req_valid = 4'b1111; req_a = 16'h4321; req_b = 16'h9ABC;
    for (int k = 0; k < 5; k++) begin
      #3 chk("rr_seq", req_ready, seq[k]);
      tick();
    end

    // Backpressure with requests pending.
    rsp_ready = 1'b0;
    repeat (5) tick();
    #3;
    chk("bp_ready", req_ready, 4'b0000);
    chk("bp_busy", busy, 1);
    chk("bp_valid", rsp_valid, 1);
    tick();
    rsp_ready = 1'b1; req_valid = 4'b0000;
    repeat (6) tick();

    // Random traffic.
    repeat (1500) begin
      req_valid = 4'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 4'b0000; rsp_ready = 1'b1;
    repeat (4) tick();

    // Exhaustive operand sweep, pair n issued by requester n%4.
    base = rsp_seen;
    for (int i = 0; i < 4; i++) nxt[i] = i;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 3000) begin
      for (int i = 0; i < 4; i++) begin
        req_valid[i]    = (nxt[i] < 256);
        req_a[4*i +: 4] = 4'(nxt[i] >> 4);
        req_b[4*i +: 4] = 4'(nxt[i]);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #3 hs = req_valid & req_ready;
      for (int i = 0; i < 4; i++) if (hs[i]) nxt[i] += 4;
      done = (nxt[0] >= 256) && (nxt[1] >= 256) && (nxt[2] >= 256) && (nxt[3] >= 256);
      tick();
      cyc++;
    end
    chk("exh_done", done, 1);
    req_valid = 4'b0000; rsp_ready = 1'b1;
    repeat (4) tick();
    chk("exh_count", rsp_seen - base, 256);

    // Fairness: requester 3 always valid, others random.
    wait3 = 0;
    repeat (300) begin
      req_valid = {1'b1, 3'($urandom)};
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      #3;
      if (req_ready[3]) begin
        chk("fair_wait_le3", wait3 <= 3, 1);
        wait3 = 0;
      end else begin
        wait3++;
      end
      tick();
    end

    // Asynchronous reset with both stages occupied.
    req_valid = 4'b1111; rsp_ready = 1'b0;
    repeat (3) tick();
    #1 chk("prerst_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_prod", rsp_prod, 0);
    chk("arst_id", rsp_id, 0);
    chk("arst_ready", req_ready, 0);
    tick();
    rst = 1'b0; rsp_ready = 1'b1;
    #3 chk("postrst_grant", req_ready, 4'b0001);
    tick();
    repeat (10) tick();

    req_valid = 4'b0000;
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
